egress_port_queue: RTL

- Per-port egress buffer placed directly downstream of one crossbar output (out_wrN/out_ctlN/out_dataN); four instances in the switch, one per PORT_ID.
- The crossbar offers no backpressure, so this block absorbs bursts in a FIFO and drops words when full.
- It checks each word's destination field, drains to the egress interface with a valid/ready handshake, and keeps saturating statistics.

---
 rtl/switch_pkg.sv | 15 +
 rtl/egress_sync_fifo.sv | 63 ++++++
 rtl/egress_port_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// Switch-wide constants shared by the crossbar and the egress queues.
// Destination field location inside the control word.
package switch_pkg;

  localparam int DST_LSB   = 0;
  localparam int DST_MSB   = 1;
  localparam int DST_W     = DST_MSB - DST_LSB + 1;
  localparam int NUM_PORTS = 4;

  localparam int CTRL_W = 32;
  localparam int DATA_W = 480;

  typedef logic [DST_W-1:0] port_id_t;

endpackage

// File: rtl/egress_sync_fifo.sv
// Storage array with pointers and level for the egress queue.
// Read data is show-ahead: rd_data is the word at rd_ptr.
module egress_sync_fifo #(
  parameter int W          = 512,
  parameter int DEPTH_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [W-1:0]        wr_data,
  input  logic                rd_en,
  output logic [W-1:0]        rd_data,
  output logic [DEPTH_BITS:0] level,
  output logic                full,
  output logic                empty,
  output logic                nearly_full
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   LVL_ONE  = 1;
  localparam logic [DEPTH_BITS:0]   LVL_FULL = DEPTH;
  localparam logic [DEPTH_BITS:0]   LVL_NF   = DEPTH - 2;
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = 1;

  logic [W-1:0]          mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_en && !rd_en) level_d = level_q + LVL_ONE;
    if (!wr_en && rd_en) level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Contents are abandoned on reset; only pointers matter.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data     = mem_q[rd_ptr_q];
  assign level       = level_q;
  assign full        = (level_q == LVL_FULL);
  assign empty       = (level_q == '0);
  assign nearly_full = (level_q >= LVL_NF);

endmodule

// File: rtl/egress_port_queue.sv
// Per-port egress queue: destination check, drop-on-full buffering,
// registered valid/ready output and saturating statistics.
module egress_port_queue
  import switch_pkg::*;
#(
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = 32,
  parameter int DEPTH_BITS = 4,
  parameter int PORT_ID    = 0,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_wr,
  input  logic [CTRL_WIDTH-1:0] in_ctl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DEPTH_BITS:0]   fifo_level,
  output logic                  nearly_full,
  input  logic                  clr_stats,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam int W = CTRL_WIDTH + DATA_WIDTH;
  localparam port_id_t MY_PORT = PORT_ID[DST_W-1:0];
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic         dst_ok, err_inc, drop_inc, push, load, deliver;
  logic         full, empty;
  logic [W-1:0] rd_data;

  logic                  valid_q, valid_d;
  logic [CTRL_WIDTH-1:0] ctl_q, ctl_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  pkt_q, pkt_d, drop_q, drop_d, err_q, err_d;

  assign dst_ok   = (in_ctl[DST_MSB:DST_LSB] == MY_PORT);
  assign err_inc  = in_wr && !dst_ok;
  assign drop_inc = in_wr && dst_ok && full;
  assign push     = in_wr && dst_ok && !full;
  assign load     = !empty && (!valid_q || out_ready);
  assign deliver  = valid_q && out_ready;

  egress_sync_fifo #(
    .W          (W),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (push),
    .wr_data     ({in_ctl, in_data}),
    .rd_en       (load),
    .rd_data     (rd_data),
    .level       (fifo_level),
    .full        (full),
    .empty       (empty),
    .nearly_full (nearly_full)
  );

  always_comb begin
    valid_d = valid_q;
    ctl_d   = ctl_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      ctl_d   = rd_data[W-1:DATA_WIDTH];
      data_d  = rd_data[DATA_WIDTH-1:0];
    end else if (deliver) begin
      valid_d = 1'b0;
    end
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    pkt_d  = pkt_q;
    drop_d = drop_q;
    err_d  = err_q;
    if (clr_stats) begin
      pkt_d  = '0;
      drop_d = '0;
      err_d  = '0;
    end else begin
      if (deliver && pkt_q != CNT_MAX)   pkt_d  = pkt_q + CNT_ONE;
      if (drop_inc && drop_q != CNT_MAX) drop_d = drop_q + CNT_ONE;
      if (err_inc && err_q != CNT_MAX)   err_d  = err_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
      data_q  <= '0;
      pkt_q   <= '0;
      drop_q  <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      data_q  <= data_d;
      pkt_q   <= pkt_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_ctl   = ctl_q;
  assign out_data  = data_q;
  assign pkt_cnt   = pkt_q;
  assign drop_cnt  = drop_q;
  assign err_cnt   = err_q;

endmodule
